// File: rtl/ir_tx_scheduler.sv
// ir_tx_scheduler: round-robin sharing of one IR transmit path between NREQ
// requesters. One frame at a time: grant, start strobe, wait for done (with
// timeout), then hold an idle gap before the next grant.
module ir_tx_scheduler #(
  parameter int NREQ          = 2,
  parameter int CODE_W        = 11,
  parameter int GAP_TICKS     = 5,
  parameter int TIMEOUT_TICKS = 50,
  parameter int CNT_W         = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*CODE_W-1:0]   code_in,
  output logic [NREQ-1:0]          ack,
  output logic                     tx_start,
  output logic [CODE_W-1:0]        tx_code,
  input  logic                     tx_done,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     err
);

  localparam int ID_W = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, LAUNCH, SEND, GAP} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [ID_W-1:0]   rr_ptr, rr_nxt;
  logic [ID_W-1:0]   winner, cand;
  logic              found;
  logic [NREQ-1:0]   ack_nxt;
  logic              start_nxt, err_nxt;
  logic [CODE_W-1:0] code_nxt;
  logic [ID_W-1:0]   grant_nxt;
  logic [CODE_W-1:0] codes [NREQ];

  // Unpack the flat code bus into one entry per requester.
  for (genvar g = 0; g < NREQ; g++) begin : g_codes
    assign codes[g] = code_in[g*CODE_W +: CODE_W];
  end

  // Round-robin pick: first set request scanning upward from rr_ptr+1 with wrap.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Next-state and registered-output decode. One counter serves both phases:
  // it counts ticks up in SEND (timeout) and down in GAP (inter-frame gap).
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rr_nxt    = rr_ptr;
    ack_nxt   = '0;
    start_nxt = 1'b0;
    err_nxt   = err;
    code_nxt  = tx_code;
    grant_nxt = grant_id;
    case (state)
      IDLE: begin
        if (found) begin
          code_nxt        = codes[winner];
          grant_nxt       = winner;
          ack_nxt[winner] = 1'b1;
          rr_nxt          = winner;
          state_nxt       = LAUNCH;
        end
      end
      LAUNCH: begin
        start_nxt = 1'b1;
        cnt_nxt   = '0;
        state_nxt = SEND;
      end
      SEND: begin
        // A done pulse beats a coincident timeout.
        if (tx_done) begin
          cnt_nxt   = CNT_W'(GAP_TICKS);
          state_nxt = GAP;
        end else if (tick) begin
          if (cnt == CNT_W'(TIMEOUT_TICKS - 1)) begin
            err_nxt   = 1'b1;
            cnt_nxt   = CNT_W'(GAP_TICKS);
            state_nxt = GAP;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      GAP: begin
        if (cnt == '0)  state_nxt = IDLE;
        else if (tick)  cnt_nxt   = cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rr_ptr   <= ID_W'(NREQ - 1);
      ack      <= '0;
      tx_start <= 1'b0;
      tx_code  <= '0;
      grant_id <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      rr_ptr   <= rr_nxt;
      ack      <= ack_nxt;
      tx_start <= start_nxt;
      tx_code  <= code_nxt;
      grant_id <= grant_nxt;
      err      <= err_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ir_tx_scheduler.sv
// Testbench for ir_tx_scheduler: directed scenario sequence with randomized
// codes and tick timing, checked against tick-counting expectations.
module tb_ir_tx_scheduler;
  localparam int NREQ = 2;
  localparam int CW   = 11;
  localparam int GAP  = 5;
  localparam int TMO  = 50;

  logic              clk = 1'b0;
  logic              rst, tick;
  logic [NREQ-1:0]   req, ack;
  logic [NREQ*CW-1:0] code_in;
  logic              tx_start, tx_done, busy, err;
  logic [CW-1:0]     tx_code;
  logic [0:0]        grant_id;

  logic [NREQ-1:0]   req2, ack2;
  logic [NREQ*CW-1:0] code_in2;
  logic              tx_start2, tx_done2, busy2, err2;
  logic [CW-1:0]     tx_code2;
  logic [0:0]        grant_id2;

  ir_tx_scheduler #(.NREQ(NREQ), .CODE_W(CW), .GAP_TICKS(GAP), .TIMEOUT_TICKS(TMO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .tick(tick), .req(req), .code_in(code_in), .ack(ack),
    .tx_start(tx_start), .tx_code(tx_code), .tx_done(tx_done), .busy(busy),
    .grant_id(grant_id), .err(err));

  ir_tx_scheduler #(.NREQ(NREQ), .CODE_W(CW), .GAP_TICKS(0), .TIMEOUT_TICKS(TMO), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .tick(tick), .req(req2), .code_in(code_in2), .ack(ack2),
    .tx_start(tx_start2), .tx_code(tx_code2), .tx_done(tx_done2), .busy(busy2),
    .grant_id(grant_id2), .err(err2));

  always #5 clk = ~clk;

  int npass = 0, ntotal = 0, nfail = 0;
  logic [CW-1:0] mcode [NREQ];
  int  mlast;
  bit  merr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given tick level; returns 1 time unit after the edge.
  task automatic cyc(input bit tk);
    tick = tk;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  // Wait (bounded) for the grant, then check the start strobe and code.
  task automatic serve(input int exp, input bit drop);
    int c = 0;
    do begin cyc(1'($urandom % 2)); c++; end while (ack == '0 && c < 10);
    chk("ack", ack, 32'd1 << exp);
    chk("grant_id", grant_id, exp);
    chk("start_with_ack", tx_start, 0);
    mlast = exp;
    if (drop) req = '0;
    cyc(1'($urandom % 2));
    chk("tx_start", tx_start, 1);
    chk("tx_code", tx_code, mcode[exp]);
    chk("ack_after", ack, 0);
    chk("busy_send", busy, 1);
  endtask

  // Deliver nt ticks in SEND (fewer than the timeout), then a done pulse.
  task automatic send_done(input int nt);
    for (int i = 0; i < nt; i++) begin
      if ($urandom % 2) begin cyc(1'b0); chk("send_busy", busy, 1); end
      cyc(1'b1);
      chk("send_busy", busy, 1);
      chk("send_start", tx_start, 0);
      chk("send_err", err, merr);
      chk("send_code", tx_code, mcode[mlast]);
    end
    tx_done = 1'b1;
    cyc(1'($urandom % 2));
    tx_done = 1'b0;
    chk("done_busy", busy, 1);
  endtask

  // Busy must hold until GAP ticks have passed, then drop one cycle later.
  task automatic gap_check();
    int  tp = 0;
    bit  done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      bit tk = 1'($urandom % 2);
      bit leave = (tp >= GAP);
      cyc(tk);
      chk("gap_start", tx_start, 0);
      if (leave) begin chk("gap_exit", busy, 0); done = 1; end
      else begin chk("gap_busy", busy, 1); tp += int'(tk); end
    end
  endtask

  initial begin
    int seq [3] = '{0, 1, 0};
    int tp;
    logic [CW-1:0] c2;
    rst = 0; tick = 0; req = '0; tx_done = 0; code_in = '0;
    req2 = '0; code_in2 = '0; tx_done2 = 0;
    merr = 0; mlast = NREQ - 1;

    // Reset with both requests held, then first grant to requester 0.
    mcode[0] = CW'($urandom); mcode[1] = CW'($urandom);
    code_in = {mcode[1], mcode[0]};
    req = 2'b11;
    repeat (3) begin
      cyc(1'b1);
      chk("rst_ack", ack, 0); chk("rst_start", tx_start, 0); chk("rst_busy", busy, 0);
    end
    chk("rst_code", tx_code, 0); chk("rst_gid", grant_id, 0); chk("rst_err", err, 0);
    rst = 1;
    cyc(1'b0);
    chk("t1_ack", ack, 2'b01); chk("t1_start", tx_start, 0); chk("t1_gid", grant_id, 0);
    mlast = 0; req = '0;
    cyc(1'b0);
    chk("t1_start", tx_start, 1); chk("t1_code", tx_code, mcode[0]);
    send_done(2);
    gap_check();

    // Both held: grants alternate 0,1,0.
    rst = 0; cyc(1'b0); rst = 1; mlast = NREQ - 1;
    mcode[0] = 11'h5A5; mcode[1] = 11'h3C3;
    code_in = {mcode[1], mcode[0]};
    req = 2'b11;
    for (int f = 0; f < 3; f++) begin
      serve(seq[f], 1'b0);
      send_done(int'($urandom_range(0, 4)));
      gap_check();
    end

    // Done coincident with the final timeout tick: done wins, no error.
    req = 2'b10;
    serve(1, 1'b1);
    tp = 0;
    for (int c = 0; c < 1000 && tp < TMO - 1; c++) begin
      bit tk = 1'($urandom % 2);
      cyc(tk); tp += int'(tk);
      chk("t4_err", err, 0); chk("t4_busy", busy, 1);
    end
    tx_done = 1'b1; cyc(1'b1); tx_done = 1'b0;
    chk("t4_err_final", err, 0); chk("t4_gap", busy, 1);
    gap_check();

    // No done at all: timeout sets sticky err, then normal service resumes.
    req = 2'b10;
    serve(1, 1'b1);
    tp = 0;
    for (int c = 0; c < 1000; c++) begin
      bit tk = ($urandom_range(0, 3) != 0);
      cyc(tk); tp += int'(tk);
      if (tp == TMO) begin
        merr = 1; chk("tmo_err", err, 1); chk("tmo_busy", busy, 1); break;
      end
      chk("pre_tmo_err", err, 0);
    end
    chk("tmo_reached", tp, TMO);
    gap_check();
    chk("err_sticky", err, 1);
    req = 2'b01;
    serve(0, 1'b1);
    send_done(3);
    gap_check();

    // Reset three cycles into a frame.
    req = 2'b01;
    serve(0, 1'b1);
    cyc(1'b0); cyc(1'b0);
    rst = 0;
    cyc(1'b0);
    chk("t5_busy", busy, 0); chk("t5_start", tx_start, 0); chk("t5_ack", ack, 0);
    chk("t5_gid", grant_id, 0); chk("t5_err", err, 0);
    merr = 0; mlast = NREQ - 1;
    rst = 1;
    for (int c = 0; c < 4; c++) begin
      tx_done = (c == 1);
      cyc(1'($urandom % 2));
      chk("t5_idle_start", tx_start, 0); chk("t5_idle_busy", busy, 0); chk("t5_idle_ack", ack, 0);
    end
    tx_done = 1'b0;
    req = 2'b11;
    serve(0, 1'b1);
    send_done(1);
    gap_check();

    // Zero-gap build: one GAP cycle, then re-grant two cycles after done.
    c2 = CW'($urandom);
    code_in2 = {11'h000, c2};
    req2 = 2'b01;
    for (int c = 0; c < 10; c++) begin
      cyc(1'b0);
      if (ack2 != '0) break;
    end
    chk("t6_ack", ack2, 2'b01);
    cyc(1'b0);
    chk("t6_start", tx_start2, 1); chk("t6_code", tx_code2, c2);
    cyc(1'b1); cyc(1'b0);
    tx_done2 = 1'b1; cyc(1'b0); tx_done2 = 1'b0;
    chk("t6_gap", busy2, 1);
    cyc(1'b0);
    chk("t6_idle", busy2, 0); chk("t6_noack", ack2, 0);
    cyc(1'b0);
    chk("t6_regrant", ack2, 2'b01);
    req2 = '0;
    cyc(1'b0);
    chk("t6_restart", tx_start2, 1);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
